mul_issue_ctrl: RTL
===================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, multiplier result latency in cycles; legal range 2..8.
REQ-002 SHALL have parameter ALU_LAT, default 1, single-cycle ALU writeback latency; legal range 1..MUL_LAT-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port issue_valid  input  1  decode presents an instruction.
REQ-006 SHALL have port issue_is_mul  input  1  presented instruction is MUL; otherwise ALU-class.
REQ-007 SHALL have ports issue_rs1, issue_rs2, issue_rd  input  5 each  source and destination register indices.
REQ-008 SHALL have port flush  input  1  squash all pending writebacks.
REQ-009 SHALL have port issue_ready  output  1  combinational; instruction accepted when issue_valid=1 and issue_ready=1.
REQ-010 SHALL have port mul_start  output  1  combinational; equals issue_valid & issue_ready & issue_is_mul; drives the multiplier operation select.
REQ-011 SHALL have ports wb_valid  output  1, wb_from_mul  output  1, wb_rd  output  5  registered; the single register-file write port schedule.
REQ-012 SHALL have port inflight  output  4  registered count of accepted MULs not yet written back.
REQ-013 SHALL have port stall_cnt  output  16  registered saturating stall counter.

Function
REQ-014 SHALL track every accepted instruction as an entry {rd, is_mul} in a writeback-slot shift structure MUL_LAT deep.
REQ-015 An instruction accepted in cycle t SHALL appear on wb_valid=1, wb_rd=rd, wb_from_mul=is_mul in exactly cycle t+MUL_LAT (MUL) or t+ALU_LAT (ALU), for that one cycle only.
REQ-016 A MUL entry SHALL count as in flight from cycle t+1 through cycle t+MUL_LAT inclusive.
REQ-017 RAW hazard: issue_ready SHALL be 0 when issue_rs1 or issue_rs2 equals the rd of any in-flight MUL with that rd != 0.
REQ-018 WAW hazard: issue_ready SHALL be 0 when issue_rd equals the rd of any in-flight MUL with that rd != 0.
REQ-019 Port conflict: issue_ready SHALL be 0 for an ALU-class instruction when an in-flight MUL owns writeback cycle t+ALU_LAT; the MUL always has priority.
REQ-020 A MUL's own slot t+MUL_LAT is always free; a MUL SHALL NOT be blocked by port conflicts.
REQ-021 Register index 0 SHALL never create a RAW or WAW hazard; x0 entries still occupy their writeback slot.
REQ-022 issue_ready SHALL be 0 whenever flush=1; otherwise it SHALL be 1 when no hazard in REQ-017..019 holds, regardless of issue_valid.
REQ-023 At most one instruction SHALL be accepted per cycle.
REQ-024 Flush in cycle t SHALL discard every entry whose writeback cycle is > t; the writeback already presented in cycle t completes; inflight SHALL read 0 in cycle t+1.
REQ-025 inflight SHALL increment on MUL accept and decrement at MUL writeback; a simultaneous accept and writeback SHALL leave it unchanged.
REQ-026 stall_cnt SHALL increment by 1 each cycle with issue_valid=1, issue_ready=0 and flush=0, and SHALL saturate at 0xFFFF.

Reset
REQ-027 While rst=0, all entries SHALL be cleared asynchronously, including any pending writeback mid-operation.
REQ-028 While rst=0: wb_valid=0, wb_from_mul=0, wb_rd=0, inflight=0, stall_cnt=0; issue_ready=1 when flush=0.
REQ-029 After rst deasserts, the first accept SHALL be possible on the next rising edge.

Verification (MUL_LAT=4, ALU_LAT=1)
REQ-030 Reset: rst low mid-stream with a MUL pending -> outputs zero immediately; no writeback after release.
REQ-031 Single MUL: MUL rd=5 accepted at cycle 0 -> wb_valid=1, wb_from_mul=1, wb_rd=5 in cycle 4 only; inflight=1 in cycles 1..4; inflight=0 in cycle 5.
REQ-032 RAW stall: MUL rd=5 at 0; ADD rs1=5 held valid from cycle 1 -> issue_ready=0 in cycles 1..4, accepted in cycle 5; stall_cnt=4.
REQ-033 Port conflict: MUL rd=6 at 0; ADD rd=7 (no hazard on registers) valid at cycle 3 -> stalled in cycle 3, accepted in cycle 4, wb_rd=7 in cycle 5 with wb_from_mul=0.
REQ-034 Back-to-back: MULs rd=1..4 in cycles 0..3 -> writebacks rd=1..4 in cycles 4..7; inflight peaks at 4 in cycle 4; x0 sources never stall.
REQ-035 Flush: MUL rd=9 at 0, flush=1 in cycle 2 -> issue_ready=0 in cycle 2; no wb_valid in cycle 4; inflight=0 in cycle 3.

Source files
------------

// File: rtl/mul_issue_ctrl_if.sv
// Issue/writeback handshake between decode and the MUL issue controller.
// Master drives the decode side; slave is the controller.
interface mul_issue_ctrl_if;
    logic        issue_valid;
    logic        issue_is_mul;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        issue_ready;
    logic        mul_start;
    logic        wb_valid;
    logic        wb_from_mul;
    logic [4:0]  wb_rd;
    logic [3:0]  inflight;
    logic [15:0] stall_cnt;

    modport master (
        output issue_valid, issue_is_mul, issue_rs1, issue_rs2, issue_rd, flush,
        input  issue_ready, mul_start, wb_valid, wb_from_mul, wb_rd, inflight, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_is_mul, issue_rs1, issue_rs2, issue_rd, flush,
        output issue_ready, mul_start, wb_valid, wb_from_mul, wb_rd, inflight, stall_cnt
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue controller for a pipelined multiplier sharing one register-file write port with the ALU.
// Tracks writeback slots, blocks RAW/WAW hazards on in-flight MULs and write-port conflicts.
module mul_issue_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    mul_issue_ctrl_if.slave bus
);
    localparam int unsigned MulIns = MUL_LAT - 1;
    localparam int unsigned AluIns = ALU_LAT - 1;

    typedef struct packed {
        logic       valid;
        logic       is_mul;
        logic [4:0] rd;
    } entry_t;

    // slot_q[j] holds the entry that writes back j cycles from now; slot_q[0] is the live writeback.
    entry_t [MUL_LAT-1:0] slot_q, slot_d;
    logic [3:0]           inflight_q, inflight_d;
    logic [15:0]          stall_q, stall_d;

    logic raw_haz, waw_haz, port_haz, ready, accept;

    always_comb begin
        raw_haz = 1'b0;
        waw_haz = 1'b0;
        for (int unsigned j = 0; j < MUL_LAT; j++) begin
            if (slot_q[j].valid && slot_q[j].is_mul && (slot_q[j].rd != 5'd0)) begin
                if ((bus.issue_rs1 == slot_q[j].rd) || (bus.issue_rs2 == slot_q[j].rd)) begin
                    raw_haz = 1'b1;
                end
                if (bus.issue_rd == slot_q[j].rd) begin
                    waw_haz = 1'b1;
                end
            end
        end
        // An ALU op would land where slot_q[ALU_LAT] shifts to; only a MUL can already sit there.
        port_haz = !bus.issue_is_mul && slot_q[ALU_LAT].valid;
        ready    = !bus.flush && !raw_haz && !waw_haz && !port_haz;
        accept   = bus.issue_valid && ready;
    end

    always_comb begin
        slot_d = '0;
        if (!bus.flush) begin
            for (int unsigned j = 0; j < MulIns; j++) begin
                slot_d[j] = slot_q[j+1];
            end
            if (accept) begin
                if (bus.issue_is_mul) begin
                    slot_d[MulIns] = '{valid: 1'b1, is_mul: 1'b1, rd: bus.issue_rd};
                end else begin
                    slot_d[AluIns] = '{valid: 1'b1, is_mul: 1'b0, rd: bus.issue_rd};
                end
            end
        end

        inflight_d = 4'd0;
        for (int unsigned j = 0; j < MUL_LAT; j++) begin
            inflight_d = inflight_d + 4'(slot_d[j].valid & slot_d[j].is_mul);
        end

        stall_d = stall_q;
        if (bus.issue_valid && !ready && !bus.flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q     <= '0;
            inflight_q <= 4'd0;
            stall_q    <= 16'd0;
        end else begin
            slot_q     <= slot_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.issue_ready = ready;
    assign bus.mul_start   = accept && bus.issue_is_mul;
    assign bus.wb_valid    = slot_q[0].valid;
    assign bus.wb_from_mul = slot_q[0].is_mul;
    assign bus.wb_rd       = slot_q[0].rd;
    assign bus.inflight    = inflight_q;
    assign bus.stall_cnt   = stall_q;
endmodule
